ps2_key_rx: RTL and testbench

PS2_KEY_RX -- requirements
Module: ps2_key_rx

---
 rtl/ps2_key_rx.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_key_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the PS/2 clock,
// deserializes 11-bit frames, and folds E0/F0 prefixes into key events.
module ps2_key_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 60000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [10:0] ps2_key,
  output logic        err_o
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state, state_nxt;

  logic          clk_p0, clk_p1;
  logic          dat_p0, dat_p1;
  logic          fclk_p2;
  logic [FW-1:0] filt_cnt;
  logic          filt_flip;
  logic          vld_p2;
  logic          bit_p2;

  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          par_ok;
  logic          ext_flag, brk_flag;

  logic          start_frm, shift_en, par_cap, byte_ok, frm_err;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_par_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // Keyboard status/ack bytes that never describe a key.
  function automatic logic is_ignored(input logic [7:0] d);
    case (d)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  // Stage p0/p1: two-flop synchronizers for both raw PS/2 lines.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk_i;
      clk_p1 <= clk_p0;
      dat_p0 <= ps2_data_i;
      dat_p1 <= dat_p0;
    end
  end

  // The filtered level flips on the FILTER-th consecutive differing sample.
  assign filt_flip = (clk_p1 != fclk_p2) && (filt_cnt == FW'(FILTER - 1));

  // Stage p2: glitch filter; a 1->0 flip of the filtered clock is the bit strobe.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      fclk_p2  <= 1'b1;
      filt_cnt <= '0;
      vld_p2   <= 1'b0;
    end else begin
      vld_p2 <= filt_flip & fclk_p2;
      if (filt_flip) begin
        fclk_p2  <= clk_p1;
        filt_cnt <= '0;
      end else if (clk_p1 != fclk_p2) begin
        filt_cnt <= filt_cnt + 1'b1;
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Stage p2 data: the data line is captured on the same flip that makes the strobe.
  always_ff @(posedge clk_sys) begin
    if (filt_flip && fclk_p2) begin
      bit_p2 <= dat_p1;
    end
  end

  // Timeout fires when the gap since the last strobe reaches TIMEOUT inside a frame.
  assign tmo_hit = (state != S_IDLE) && (tmo_cnt == TW'(TIMEOUT - 1));

  // Frame state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame sequencing; a timeout overrides any strobe landing in the same cycle.
  always_comb begin
    state_nxt = state;
    start_frm = 1'b0;
    shift_en  = 1'b0;
    par_cap   = 1'b0;
    byte_ok   = 1'b0;
    frm_err   = 1'b0;
    if (tmo_hit) begin
      state_nxt = S_IDLE;
      frm_err   = 1'b1;
    end else if (vld_p2) begin
      case (state)
        S_IDLE: begin
          if (!bit_p2) begin
            state_nxt = S_DATA;
            start_frm = 1'b1;
          end
        end
        S_DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_nxt = S_PARITY;
          end
        end
        S_PARITY: begin
          par_cap   = 1'b1;
          state_nxt = S_STOP;
        end
        S_STOP: begin
          state_nxt = S_IDLE;
          if (bit_p2 && par_ok) begin
            byte_ok = 1'b1;
          end else begin
            frm_err = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame counters; parity verdict is held so both error kinds report at the stop bit.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      tmo_cnt <= '0;
      par_ok  <= 1'b0;
    end else begin
      if (start_frm) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state_nxt == S_IDLE) begin
        tmo_cnt <= '0;
      end else if (vld_p2) begin
        tmo_cnt <= TW'(1);
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (par_cap) begin
        par_ok <= odd_par_ok(shift, bit_p2);
      end
    end
  end

  // Deserializer, LSB first.
  always_ff @(posedge clk_sys) begin
    if (shift_en) begin
      shift <= {bit_p2, shift[7:1]};
    end
  end

  // Stage p3: prefix flags, key event register and error pulse.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ps2_key  <= '0;
      err_o    <= 1'b0;
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else begin
      err_o <= frm_err;
      if (frm_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_ok) begin
        if (shift == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (shift == 8'hF0) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          if (!is_ignored(shift)) begin
            ps2_key <= {~ps2_key[10], ~brk_flag, ext_flag, shift};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: stimulus pushes expected events, a monitor pops them.
`timescale 1ns/1ps
module tb_ps2_key_rx;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 1000;
  localparam int HALF    = 30;
  localparam int LAT_BIT = FILTER + 3;
  localparam int LAT_TMO = FILTER + TIMEOUT + 2;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk_i = 1'b1;
  logic        ps2_data_i = 1'b1;
  logic [10:0] ps2_key;
  logic        err_o;

  ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_key    (ps2_key),
    .err_o      (err_o)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [10:0] key;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   last_fall = 0;

  // Reference model state: prefix flags and event toggle.
  bit m_ext = 0, m_brk = 0, m_tog = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_chk++;
    $display("FAIL %s: got 0x%0h with no event expected", name, act);
  endtask

  task automatic push_err(input int lat);
    exp_t e;
    e.is_err = 1'b1;
    e.key    = '0;
    e.lat    = lat;
    exp_q.push_back(e);
    m_ext = 0;
    m_brk = 0;
  endtask

  // Byte-level behaviour of a keyboard decoder; optionally override the event value.
  task automatic model_frame(input logic [7:0] b, input bit bad_par,
                             input bit use_const, input logic [10:0] kconst);
    exp_t e;
    if (bad_par) begin
      push_err(LAT_BIT);
      return;
    end
    case (b)
      8'hE0: m_ext = 1;
      8'hF0: m_brk = 1;
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1: begin
        m_ext = 0;
        m_brk = 0;
      end
      default: begin
        m_tog    = ~m_tog;
        e.is_err = 1'b0;
        e.key    = use_const ? kconst : {m_tog, ~m_brk, m_ext, b};
        e.lat    = LAT_BIT;
        exp_q.push_back(e);
        m_ext = 0;
        m_brk = 0;
      end
    endcase
  endtask

  task automatic send_bit(input logic v, input bit glitch);
    @(negedge clk_sys);
    ps2_data_i = v;
    if (glitch) begin
      repeat (10) @(negedge clk_sys);
      ps2_clk_i = 1'b0;
      repeat (3) @(negedge clk_sys);
      ps2_clk_i = 1'b1;
      repeat (HALF - 13) @(negedge clk_sys);
    end else begin
      repeat (HALF) @(negedge clk_sys);
    end
    ps2_clk_i = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk_i = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int glitch_bit, input int n_bits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < n_bits; i++) send_bit(bits[i], i == glitch_bit);
    repeat (20) @(negedge clk_sys);
  endtask

  task automatic send_key(input logic [7:0] b, input logic [10:0] kconst);
    model_frame(b, 1'b0, 1'b1, kconst);
    send_frame(b, 1'b0, -1, 11);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input int glitch_bit);
    model_frame(b, bad_par, 1'b0, '0);
    send_frame(b, bad_par, glitch_bit, 11);
  endtask

  // Monitor: every key change or err_o pulse must match the head of the queue.
  initial begin
    logic [10:0] last_key;
    exp_t        e;
    last_key = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (reset) begin
        last_key = '0;
      end else begin
        if (ps2_key !== last_key) begin
          if (exp_q.size() == 0) unexpected("key_change", ps2_key);
          else begin
            e = exp_q.pop_front();
            check("event_kind_key", 0, e.is_err);
            check("ps2_key", ps2_key, e.key);
            check_rng("key_latency", cyc - last_fall, e.lat - 1, e.lat + 1);
          end
          last_key = ps2_key;
        end
        if (err_o === 1'b1) begin
          if (exp_q.size() == 0) unexpected("err_o", err_o);
          else begin
            e = exp_q.pop_front();
            check("event_kind_err", 1, e.is_err);
            check_rng("err_latency", cyc - last_fall, e.lat - 1, e.lat + 1);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout at %0t, want completion", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] specials [7];
    logic [7:0] b;
    int         r;
    specials = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1};

    repeat (5) @(negedge clk_sys);
    check("reset_ps2_key", ps2_key, 11'h000);
    check("reset_err_o", err_o, 1'b0);
    reset = 1'b0;
    repeat (20) @(negedge clk_sys);

    // Glitch while idle must not start a frame.
    ps2_clk_i = 1'b0;
    repeat (3) @(negedge clk_sys);
    ps2_clk_i = 1'b1;
    repeat (20) @(negedge clk_sys);

    send_key(8'h1C, 11'h61C);
    model_frame(8'hF0, 1'b0, 1'b0, '0); send_frame(8'hF0, 1'b0, -1, 11);
    send_key(8'h1C, 11'h01C);
    model_frame(8'hE0, 1'b0, 1'b0, '0); send_frame(8'hE0, 1'b0, -1, 11);
    send_key(8'h75, 11'h775);
    model_frame(8'hE0, 1'b0, 1'b0, '0); send_frame(8'hE0, 1'b0, -1, 11);
    model_frame(8'hF0, 1'b0, 1'b0, '0); send_frame(8'hF0, 1'b0, -1, 11);
    send_key(8'h75, 11'h175);

    // Parity error after an E0 prefix drops the byte and the prefix.
    send_byte(8'hE0, 1'b0, -1);
    send_byte(8'h1C, 1'b1, -1);
    send_byte(8'h1C, 1'b0, -1);

    // Glitch in the middle of a frame.
    send_byte(8'h1C, 1'b0, 4);
    send_byte(8'h5A, 1'b0, 0);

    // Timeout: start plus four data bits, then the clock stops.
    send_byte(8'hE0, 1'b0, -1);
    send_frame(8'h1C, 1'b0, -1, 5);
    push_err(LAT_TMO);
    repeat (TIMEOUT + 100) @(negedge clk_sys);
    send_byte(8'h1C, 1'b0, -1);

    // Reset mid-frame after data bit 5.
    send_byte(8'h29, 1'b0, -1);
    send_frame(8'h1C, 1'b0, -1, 7);
    reset = 1'b1;
    m_tog = 0; m_ext = 0; m_brk = 0;
    repeat (4) @(negedge clk_sys);
    check("midreset_ps2_key", ps2_key, 11'h000);
    check("midreset_err_o", err_o, 1'b0);
    reset = 1'b0;
    repeat (20) @(negedge clk_sys);
    send_key(8'h1C, 11'h61C);

    // Randomized byte stream mixing prefixes, ignored bytes and parity faults.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else if (r == 2) b = specials[$urandom_range(0, 6)];
      else             b = 8'($urandom_range(0, 255));
      send_byte(b, $urandom_range(0, 11) == 0, -1);
    end

    repeat (200) @(negedge clk_sys);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
